nx_node_control_inputs: RTL and testbench



---
 rtl/nx_node_control_inputs_pkg.sv | 26 ++
 rtl/nx_node_input_stage.sv | 69 ++++++
 rtl/nx_node_control_inputs.sv | 117 +++++++++++
 tb/tb_nx_node_control_inputs.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/nx_node_control_inputs_pkg.sv
// rtl/nx_node_control_inputs_pkg.sv - shared types for the node control-input path
//
// Purpose: message and FSM types shared by the control-input stage, its
//          staging datapath and the testbench.
// Contents:
//   MSG_INDEX_W    width of the message index field (wider than any legal
//                  INPUTS index, so out-of-range indices can be expressed)
//   node_signal_t  decoded signal message {index, is_seq, state}
//   input_fsm_t    trigger FSM states {IDLE, FIRE, WAIT}
package nx_node_control_inputs_pkg;

  localparam int MSG_INDEX_W = 9;

  typedef struct packed {
    logic [MSG_INDEX_W-1:0] index;
    logic                   is_seq;
    logic                   state;
  } node_signal_t;

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    WAIT
  } input_fsm_t;

endpackage

// File: rtl/nx_node_input_stage.sv
// rtl/nx_node_input_stage.sv - per-input staging datapath with tick merge
//
// Purpose: holds combinational input values (stage), sequential values
//          pending the next tick (seq + mask) and merges them on i_tick.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_tick          global tick: merge masked seq values into stage
//   i_wr_en         apply one in-range message this cycle
//   i_wr_index      input index of the message
//   i_wr_seq        1 = sequential (held until tick), 0 = combinational
//   i_wr_state      value carried by the message
//   o_stage         current staged input vector
module nx_node_input_stage #(
  parameter int INPUTS  = 32,
  parameter int INDEX_W = $clog2(INPUTS)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_wr_en,
  input  logic [INDEX_W-1:0] i_wr_index,
  input  logic               i_wr_seq,
  input  logic               i_wr_state,
  output logic [INPUTS-1:0]  o_stage
);

  logic [INPUTS-1:0] r_stage;
  logic [INPUTS-1:0] r_seq;
  logic [INPUTS-1:0] r_mask;
  logic [INPUTS-1:0] w_stage_nxt;
  logic [INPUTS-1:0] w_seq_nxt;
  logic [INPUTS-1:0] w_mask_nxt;

  // Tick merge is evaluated first; a same-cycle message is then layered on
  // top, so a combinational write overrides the merged bit and a sequential
  // write lands in the freshly cleared mask for the following tick.
  always_comb begin
    w_stage_nxt = r_stage;
    w_seq_nxt   = r_seq;
    w_mask_nxt  = r_mask;
    if (i_tick) begin
      w_stage_nxt = (r_stage & ~r_mask) | (r_seq & r_mask);
      w_mask_nxt  = '0;
    end
    if (i_wr_en) begin
      if (i_wr_seq) begin
        w_seq_nxt[i_wr_index]  = i_wr_state;
        w_mask_nxt[i_wr_index] = 1'b1;
      end else begin
        w_stage_nxt[i_wr_index] = i_wr_state;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stage <= '0;
      r_seq   <= '0;
      r_mask  <= '0;
    end else begin
      r_stage <= w_stage_nxt;
      r_seq   <= w_seq_nxt;
      r_mask  <= w_mask_nxt;
    end
  end

  assign o_stage = r_stage;

endmodule

// File: rtl/nx_node_control_inputs.sv
// rtl/nx_node_control_inputs.sv - message-driven input staging and core trigger
//
// Purpose: accepts decoded signal messages, stages per-input values and
//          fires a one-cycle evaluate strobe to the logic core.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_tick           global simulation tick (single-cycle pulse)
//   o_idle           no pending work and no live message
//   o_err            sticky: out-of-range message dropped
//   i_msg_data       decoded message {index, is_seq, state}
//   i_msg_valid      message valid
//   o_msg_ready      message ready (1 in every cycle after reset)
//   o_core_inputs    input vector presented to the logic core
//   o_core_trigger   one-cycle evaluate strobe
//   i_core_idle      logic core idle
module nx_node_control_inputs
  import nx_node_control_inputs_pkg::*;
#(
  parameter int INPUTS  = 32,
  parameter int INDEX_W = $clog2(INPUTS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_tick,
  output logic              o_idle,
  output logic              o_err,
  input  node_signal_t      i_msg_data,
  input  logic              i_msg_valid,
  output logic              o_msg_ready,
  output logic [INPUTS-1:0] o_core_inputs,
  output logic              o_core_trigger,
  input  logic              i_core_idle
);

  input_fsm_t        r_state;
  logic              r_dirty;
  logic              r_err;
  logic              r_msg_ready;
  logic              r_core_trigger;
  logic [INPUTS-1:0] r_core_inputs;

  logic              w_accept;
  logic              w_in_range;
  logic              w_wr_en;
  logic              w_set_dirty;
  logic [INPUTS-1:0] w_stage;

  assign w_accept    = i_msg_valid & r_msg_ready;
  assign w_in_range  = (32'(i_msg_data.index) < 32'(INPUTS));
  assign w_wr_en     = w_accept & w_in_range;
  // Sequential messages do not dirty the core; only their tick does.
  assign w_set_dirty = (w_wr_en & ~i_msg_data.is_seq) | i_tick;

  nx_node_input_stage #(
    .INPUTS  (INPUTS),
    .INDEX_W (INDEX_W)
  ) u_stage (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_tick     (i_tick),
    .i_wr_en    (w_wr_en),
    .i_wr_index (i_msg_data.index[INDEX_W-1:0]),
    .i_wr_seq   (i_msg_data.is_seq),
    .i_wr_state (i_msg_data.state),
    .o_stage    (w_stage)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_dirty        <= 1'b0;
      r_err          <= 1'b0;
      r_msg_ready    <= 1'b0;
      r_core_trigger <= 1'b0;
      r_core_inputs  <= '0;
    end else begin
      r_msg_ready <= 1'b1;
      if (w_accept && !w_in_range) begin
        r_err <= 1'b1;
      end
      if (w_set_dirty) begin
        r_dirty <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (r_dirty && i_core_idle) begin
            r_state        <= FIRE;
            r_core_trigger <= 1'b1;
            r_core_inputs  <= w_stage;
            // Work arriving on the sampling edge is not in this snapshot.
            r_dirty        <= w_set_dirty;
          end
        end
        FIRE: begin
          r_core_trigger <= 1'b0;
          r_state        <= WAIT;
        end
        WAIT: begin
          if (i_core_idle) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state        <= IDLE;
          r_core_trigger <= 1'b0;
        end
      endcase
    end
  end

  assign o_idle         = (r_state == IDLE) && !r_dirty && !i_msg_valid;
  assign o_err          = r_err;
  assign o_msg_ready    = r_msg_ready;
  assign o_core_inputs  = r_core_inputs;
  assign o_core_trigger = r_core_trigger;

endmodule

// File: tb/tb_nx_node_control_inputs.sv
// tb/tb_nx_node_control_inputs.sv - directed and randomized bench for nx_node_control_inputs
module tb_nx_node_control_inputs;
  import nx_node_control_inputs_pkg::*;

  localparam int INPUTS = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              tick;
  logic              idle;
  logic              err;
  node_signal_t      msg_data;
  logic              msg_valid;
  logic              msg_ready;
  logic [INPUTS-1:0] core_inputs;
  logic              trig;
  logic              core_idle;

  always #5 clk = ~clk;

  nx_node_control_inputs #(.INPUTS(INPUTS)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_tick         (tick),
    .o_idle         (idle),
    .o_err          (err),
    .i_msg_data     (msg_data),
    .i_msg_valid    (msg_valid),
    .o_msg_ready    (msg_ready),
    .o_core_inputs  (core_inputs),
    .o_core_trigger (trig),
    .i_core_idle    (core_idle)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int fires  = 0;
  int f0;

  // Reference model: the committed input vector plus an ordered list of
  // sequential writes waiting for the next tick.
  logic [INPUTS-1:0] m_stage;
  logic [INPUTS-1:0] last_fired;
  bit                m_err;
  bit                prev_trig;
  int                pend_idx[$];
  bit                pend_st[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stage    = '0;
    last_fired = '0;
    m_err      = 1'b0;
    prev_trig  = 1'b0;
    pend_idx.delete();
    pend_st.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    msg_valid = 1'b0;
    tick      = 1'b0;
    core_idle = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_inputs", 64'(core_inputs), 64'd0);
    chk("rst_trig", 64'(trig), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ready", 64'(msg_ready), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input bit v, input int idx, input bit sq, input bit st,
                      input bit tk, input bit ci);
    bit acc;
    @(negedge clk);
    msg_valid       = v;
    msg_data.index  = 9'(idx);
    msg_data.is_seq = sq;
    msg_data.state  = st;
    tick            = tk;
    core_idle       = ci;
    #1;
    acc = v && msg_ready;
    @(posedge clk);
    #1;
    if (trig) begin
      chk("fire_vec", 64'(core_inputs), 64'(m_stage));
      chk("trig_width", 64'(prev_trig), 64'd0);
      last_fired = m_stage;
      fires++;
    end else begin
      chk("hold_vec", 64'(core_inputs), 64'(last_fired));
    end
    prev_trig = trig;
    if (tk) begin
      for (int i = 0; i < pend_idx.size(); i++) m_stage[pend_idx[i]] = pend_st[i];
      pend_idx.delete();
      pend_st.delete();
    end
    if (acc) begin
      if (idx >= INPUTS) m_err = 1'b1;
      else if (sq) begin
        pend_idx.push_back(idx);
        pend_st.push_back(st);
      end else m_stage[idx] = st;
    end
    chk("err", 64'(err), 64'(m_err));
  endtask

  task automatic nop(input bit ci);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0, ci);
  endtask

  initial begin
    rst       = 1'b1;
    tick      = 1'b0;
    msg_valid = 1'b0;
    msg_data  = '0;
    core_idle = 1'b1;
    model_reset();
    do_reset();

    // Quiet after reset
    repeat (5) nop(1'b1);
    chk("t1_inputs", 64'(core_inputs), 64'd0);
    chk("t1_trig", 64'(trig), 64'd0);
    chk("t1_idle", 64'(idle), 64'd1);
    chk("t1_ready", 64'(msg_ready), 64'd1);

    // Combinational message: trigger two cycles after acceptance
    step(1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t2_trig_n1", 64'(trig), 64'd0);
    nop(1'b1);
    chk("t2_trig_n2", 64'(trig), 64'd1);
    chk("t2_vec", 64'(core_inputs), 64'h8);
    nop(1'b1);
    nop(1'b1);
    chk("t2_idle", 64'(idle), 64'd1);

    // Sequential message is held until tick
    f0 = fires;
    step(1'b1, 5, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (10) nop(1'b1);
    chk("t3_no_fire", 64'(fires), 64'(f0));
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    nop(1'b1);
    chk("t3_trig", 64'(trig), 64'd1);
    chk("t3_bit5", 64'(core_inputs[5]), 64'd1);
    nop(1'b1);
    nop(1'b1);

    // Tick and sequential message in the same cycle
    step(1'b1, 2, 1'b1, 1'b1, 1'b1, 1'b1);
    nop(1'b1);
    chk("t4_trig1", 64'(trig), 64'd1);
    chk("t4_bit2_low", 64'(core_inputs[2]), 64'd0);
    nop(1'b1);
    nop(1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    nop(1'b1);
    chk("t4_trig2", 64'(trig), 64'd1);
    chk("t4_bit2_high", 64'(core_inputs[2]), 64'd1);
    nop(1'b1);
    nop(1'b1);

    // Messages while the core is busy coalesce into one fire
    do_reset();
    nop(1'b0);
    f0 = fires;
    step(1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (18) nop(1'b0);
    chk("t5_busy_no_fire", 64'(fires), 64'(f0));
    repeat (6) nop(1'b1);
    chk("t5_one_fire", 64'(fires), 64'(f0 + 1));
    chk("t5_vec", 64'(core_inputs), 64'h3);

    // Out-of-range index
    f0 = fires;
    step(1'b1, INPUTS, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t6_err", 64'(err), 64'd1);
    repeat (5) nop(1'b1);
    chk("t6_no_fire", 64'(fires), 64'(f0));
    chk("t6_vec", 64'(core_inputs), 64'h3);
    chk("t6_err_sticky", 64'(err), 64'd1);

    // Reset while waiting on a busy core
    step(1'b1, 7, 1'b0, 1'b1, 1'b0, 1'b1);
    nop(1'b1);
    chk("t7_fire", 64'(trig), 64'd1);
    nop(1'b0);
    nop(1'b0);
    chk("t7_waiting", 64'(idle), 64'd0);
    do_reset();
    nop(1'b1);

    // Randomized traffic against the model
    repeat (3000) begin
      step(($urandom % 3) == 0, int'($urandom_range(0, INPUTS + 2)), 1'($urandom),
           1'($urandom), ($urandom % 10) == 0, ($urandom % 4) != 0);
    end
    repeat (10) nop(1'b1);
    chk("rnd_drain_vec", 64'(core_inputs), 64'(m_stage));
    chk("rnd_drain_idle", 64'(idle), 64'd1);

    // A tick alone always causes one evaluation
    f0 = fires;
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    nop(1'b1);
    nop(1'b1);
    chk("tick_fire", 64'(fires), 64'(f0 + 1));
    chk("tick_vec", 64'(core_inputs), 64'(m_stage));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
